alu_seq: RTL and testbench

//  Parametrised, registered successor of the 6502 datapath ALU. Executes one

---
 rtl/alu_seq.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered ALU for the CPU core's operand-to-writeback path.
//            Accepts one arithmetic, logic or shift operation per
//            valid/ready transaction. It returns a result plus the
//            N/Z/C/V flags.
//            Binary operations take a single cycle. With ALU_SEQ_BCD_EN
//            defined, decimal ADD/SUB run one nibble per cycle.
// Macro    : ALU_SEQ_BCD_EN - enables decimal (BCD) add/subtract
//            (cmd 0/1 with dec=1). When undefined, dec is ignored.
// Ports    : clk, rst         clock, synchronous active-high reset
//            in_valid/ready   operand handshake (cmd, dec, ci, data_a, data_b)
//            out_valid/ready  result handshake (result, no, zo, co, vo)
// Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        cmd,
   input  logic              dec,
   input  logic              ci,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              no,
   output logic              zo,
   output logic              co,
   output logic              vo
);

   localparam int MSB = DATA_W - 1;

   localparam logic [3:0] CMD_ADD = 4'd0;
   localparam logic [3:0] CMD_SUB = 4'd1;
   localparam logic [3:0] CMD_OR  = 4'd2;
   localparam logic [3:0] CMD_AND = 4'd3;
   localparam logic [3:0] CMD_XOR = 4'd4;
   localparam logic [3:0] CMD_LSL = 4'd5;
   localparam logic [3:0] CMD_LSR = 4'd6;
   localparam logic [3:0] CMD_ROL = 4'd7;
   localparam logic [3:0] CMD_ROR = 4'd8;
   localparam logic [3:0] CMD_ASR = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [3:0]        flags_q, flags_d;     // {n, z, c, v}

   logic              accept;
   logic [DATA_W:0]   arith;
   logic [DATA_W-1:0] bin_res;
   logic              bin_co;
   logic              bin_vo;

   // ------------------------------------------------------------------
   // Handshake: a new op may enter while the previous result is being
   // consumed, so DONE->DONE/BUSY back-to-back runs at full rate.
   // ------------------------------------------------------------------
   assign in_ready  = ~rst & ((state_q == S_IDLE) |
                              ((state_q == S_DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign {no, zo, co, vo} = flags_q;

   // ------------------------------------------------------------------
   // Single-cycle binary datapath, evaluated on the live inputs so the
   // result can be registered on the accepting edge.
   // ------------------------------------------------------------------
   always_comb begin
      arith   = '0;
      bin_res = '0;
      bin_co  = 1'b0;
      bin_vo  = 1'b0;
      case (cmd)
         CMD_ADD: begin
            arith   = {1'b0, data_a} + {1'b0, data_b} + {{DATA_W{1'b0}}, ci};
            bin_res = arith[MSB:0];
            bin_co  = arith[DATA_W];
            bin_vo  = (data_a[MSB] == data_b[MSB]) & (bin_res[MSB] != data_a[MSB]);
         end
         CMD_SUB: begin
            // The extra top bit goes to 1 exactly when the subtraction wraps,
            // which is the borrow.
            arith   = {1'b0, data_a} - {1'b0, data_b} - {{DATA_W{1'b0}}, ci};
            bin_res = arith[MSB:0];
            bin_co  = arith[DATA_W];
            bin_vo  = (data_a[MSB] != data_b[MSB]) & (bin_res[MSB] != data_a[MSB]);
         end
         CMD_OR:  bin_res = data_a | data_b;
         CMD_AND: bin_res = data_a & data_b;
         CMD_XOR: bin_res = data_a ^ data_b;
         CMD_LSL: {bin_co, bin_res} = {data_a, 1'b0};
         CMD_LSR: {bin_res, bin_co} = {1'b0, data_a};
         CMD_ROL: {bin_co, bin_res} = {data_a, ci};
         CMD_ROR: {bin_res, bin_co} = {ci, data_a};
         CMD_ASR: {bin_res, bin_co} = {data_a[MSB], data_a};
         default: bin_res = '0;   // reserved codes yield zero with Z set
      endcase
   end

`ifdef ALU_SEQ_BCD_EN
   // ------------------------------------------------------------------
   // Decimal engine: one digit per cycle, LSB first. Digit 0 is computed
   // on the accepting edge from the live inputs, so BUSY only covers
   // digits 1..NIB-1 and the result appears NIB cycles after accept.
   // ------------------------------------------------------------------
   localparam int              NIB      = DATA_W / 4;
   localparam int              NIB_W    = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIB - 1);

   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] work_q, work_d;     // digits finished so far
   logic [NIB_W-1:0]  nib_q, nib_d;       // digit being processed in BUSY
   logic              sub_q, sub_d;
   logic              dcy_q, dcy_d;       // digit carry/borrow chain
   logic              dvo_q, dvo_d;       // V from the binary view of the op

   logic              busy;
   logic              start_dec;
   logic [NIB_W-1:0]  nib_sel;
   logic [3:0]        dig_a, dig_b, dig_out;
   logic              dig_cin, dig_sub, dig_cout;
   logic [4:0]        dig_raw;
   logic [DATA_W-1:0] dec_word;

   assign busy      = (state_q == S_BUSY);
   assign start_dec = dec & ((cmd == CMD_ADD) | (cmd == CMD_SUB));

   always_comb begin
      nib_sel = '0;
      dig_a   = data_a[3:0];
      dig_b   = data_b[3:0];
      dig_cin = ci;
      dig_sub = (cmd == CMD_SUB);
      if (busy) begin
         nib_sel = nib_q;
         dig_a   = a_q[{nib_q, 2'b00} +: 4];
         dig_b   = b_q[{nib_q, 2'b00} +: 4];
         dig_cin = dcy_q;
         dig_sub = sub_q;
      end
   end

   // Digit adjust. Digits above 9 are not rejected; they simply follow
   // the same +6 / -6 correction.
   always_comb begin
      dig_raw  = '0;
      dig_out  = '0;
      dig_cout = 1'b0;
      if (!dig_sub) begin
         dig_raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, dig_cin};
         if (dig_raw > 5'd9) begin
            dig_out  = dig_raw[3:0] + 4'd6;
            dig_cout = 1'b1;
         end else begin
            dig_out  = dig_raw[3:0];
         end
      end else begin
         // 5-bit two's complement: bit 4 set means the digit went negative.
         dig_raw = {1'b0, dig_a} - {1'b0, dig_b} - {4'b0000, dig_cin};
         if (dig_raw[4]) begin
            dig_out  = dig_raw[3:0] - 4'd6;
            dig_cout = 1'b1;
         end else begin
            dig_out  = dig_raw[3:0];
         end
      end
      dec_word = busy ? work_q : '0;
      dec_word[{nib_sel, 2'b00} +: 4] = dig_out;
   end
`else
   // dec has no effect without the decimal engine.
   logic unused_dec;
   assign unused_dec = dec;
`endif

   // ------------------------------------------------------------------
   // Control FSM: next state and register updates.
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef ALU_SEQ_BCD_EN
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      nib_d    = nib_q;
      sub_d    = sub_q;
      dcy_d    = dcy_q;
      dvo_d    = dvo_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            // Result is handed over; in IDLE this is a no-op.
            if (out_ready) begin
               state_d = S_IDLE;
            end
            if (accept) begin
               state_d  = S_DONE;
               result_d = bin_res;
               flags_d  = {bin_res[MSB], (bin_res == '0), bin_co, bin_vo};
`ifdef ALU_SEQ_BCD_EN
               if (start_dec) begin
                  // Previous result stays put until the decimal op finishes.
                  state_d  = S_BUSY;
                  result_d = result_q;
                  flags_d  = flags_q;
                  a_d      = data_a;
                  b_d      = data_b;
                  sub_d    = (cmd == CMD_SUB);
                  work_d   = dec_word;
                  dcy_d    = dig_cout;
                  dvo_d    = bin_vo;
                  nib_d    = NIB_W'(1);
               end
`endif
            end
         end
`ifdef ALU_SEQ_BCD_EN
         S_BUSY: begin
            if (nib_q == LAST_NIB) begin
               state_d  = S_DONE;
               result_d = dec_word;
               flags_d  = {dec_word[MSB], (dec_word == '0), dig_cout, dvo_q};
            end else begin
               nib_d    = nib_q + 1'b1;
               work_d   = dec_word;
               dcy_d    = dig_cout;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         flags_q  <= '0;
`ifdef ALU_SEQ_BCD_EN
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         nib_q    <= '0;
         sub_q    <= 1'b0;
         dcy_q    <= 1'b0;
         dvo_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
`ifdef ALU_SEQ_BCD_EN
         a_q      <= a_d;
         b_q      <= b_d;
         work_q   <= work_d;
         nib_q    <= nib_d;
         sub_q    <= sub_d;
         dcy_q    <= dcy_d;
         dvo_q    <= dvo_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (DATA_W=16). It combines
//            directed vectors, handshake and reset sequences, and random
//            ops against a reference model. Expected decimal behaviour
//            follows the ALU_SEQ_BCD_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

   localparam int W   = 16;
   localparam int NIB = W / 4;
`ifdef ALU_SEQ_BCD_EN
   localparam bit BCD = 1'b1;
`else
   localparam bit BCD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   cmd;
   logic         dec;
   logic         ci;
   logic [W-1:0] data_a;
   logic [W-1:0] data_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         no, zo, co, vo;

   always #5 clk = ~clk;

   alu_seq #(.DATA_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cmd       (cmd),
      .dec       (dec),
      .ci        (ci),
      .data_a    (data_a),
      .data_b    (data_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .no        (no),
      .zo        (zo),
      .co        (co),
      .vo        (vo)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference model, written directly from the arithmetic definitions.
   // Flags are packed {n, z, c, v}.
   function automatic void model(input logic [3:0] c, input logic d, input logic cin,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [3:0] f,
                                 output int lat);
      int   s, da, db, t, k;
      logic cy, v;
      r = '0; cy = 1'b0; v = 1'b0; lat = 1; s = 0;
      case (c)
         4'd0: begin
            s  = int'(a) + int'(b) + int'(cin);
            r  = s[W-1:0];
            cy = (s > 65535);
            v  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd1: begin
            s  = int'(a) - int'(b) - int'(cin);
            r  = s[W-1:0];
            cy = (s < 0);
            v  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd2: r = a | b;
         4'd3: r = a & b;
         4'd4: r = a ^ b;
         4'd5: begin r = a << 1; cy = a[W-1]; end
         4'd6: begin r = a >> 1; cy = a[0]; end
         4'd7: begin r = (a << 1) | {15'b0, cin}; cy = a[W-1]; end
         4'd8: begin r = (a >> 1) | {cin, 15'b0}; cy = a[0]; end
         4'd9: begin r = $signed(a) >>> 1; cy = a[0]; end
         default: r = '0;
      endcase
      if (BCD && d && (c < 4'd2)) begin
         k = int'(cin);
         r = '0;
         for (int i = 0; i < NIB; i++) begin
            da = int'((a >> (4 * i)) & 16'h000F);
            db = int'((b >> (4 * i)) & 16'h000F);
            if (c == 4'd0) begin
               t = da + db + k;
               if (t > 9) begin t = t + 6; k = 1; end else k = 0;
            end else begin
               t = da - db - k;
               if (t < 0) begin t = t - 6; k = 1; end else k = 0;
            end
            r[4*i +: 4] = t[3:0];
         end
         cy  = (k != 0);
         lat = NIB;
      end
      f = {r[W-1], (r == '0), cy, v};
   endfunction

   // Issues one op from IDLE, waits for the result, holds it for `hold`
   // cycles of backpressure, then drains it. Called and returns at negedge.
   task automatic run_op(input logic [3:0] c, input logic d, input logic cin,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         output logic [W-1:0] r, output logic [3:0] f, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      cmd = c; dec = d; ci = cin; data_a = a; data_b = b; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      repeat (hold) @(negedge clk);
      r = result;
      f = {no, zo, co, vo};
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [3:0]   cmd;
      logic         dec;
      logic         ci;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic [3:0]   f;
      int           lat;
      string        name;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] r_got, r_exp;
      logic [3:0]   f_got, f_exp;
      int           lat_got, lat_exp;
      logic [3:0]   rc;
      logic         rd, rci;
      logic [W-1:0] ra, rb;

      //            cmd   dec   ci    a         b         result    nzcv     lat
      tbl.push_back('{4'd0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1, "add_ovf"});
      tbl.push_back('{4'd1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1, "sub_borrow"});
      tbl.push_back('{4'd1, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 4'b0100, 1, "sub_zero"});
      tbl.push_back('{4'd8, 1'b0, 1'b1, 16'h0001, 16'h1234, 16'h8000, 4'b1010, 1, "ror_ci"});
      tbl.push_back('{4'd9, 1'b0, 1'b0, 16'h8002, 16'h0000, 16'hC001, 4'b1000, 1, "asr"});
      tbl.push_back('{4'd2, 1'b0, 1'b0, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b1000, 1, "or"});
      tbl.push_back('{4'd3, 1'b0, 1'b1, 16'hF0F0, 16'h0F0F, 16'h0000, 4'b0100, 1, "and"});
      tbl.push_back('{4'd4, 1'b0, 1'b0, 16'h1234, 16'h00FF, 16'h12CB, 4'b0000, 1, "xor"});
      tbl.push_back('{4'd5, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'h0002, 4'b0010, 1, "lsl"});
      tbl.push_back('{4'd6, 1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0001, 4'b0010, 1, "lsr"});
      tbl.push_back('{4'd7, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'h0001, 4'b0010, 1, "rol"});
      tbl.push_back('{4'd12, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1, "reserved"});
      tbl.push_back('{4'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1, "add_wrap"});
      tbl.push_back('{4'd1, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1, "sub_ovf"});
      tbl.push_back('{4'd1, 1'b0, 1'b1, 16'h0010, 16'h0001, 16'h000E, 4'b0000, 1, "sub_ci"});
      tbl.push_back('{4'd2, 1'b1, 1'b0, 16'h00F0, 16'h000F, 16'h00FF, 4'b0000, 1, "or_dec_ignored"});
      tbl.push_back('{4'd0, 1'b1, 1'b1, 16'h0058, 16'h0046,
                      BCD ? 16'h0105 : 16'h009F, 4'b0000, BCD ? NIB : 1, "dec_add"});
      tbl.push_back('{4'd1, 1'b1, 1'b0, 16'h0010, 16'h0001,
                      BCD ? 16'h0009 : 16'h000F, 4'b0000, BCD ? NIB : 1, "dec_sub"});
      tbl.push_back('{4'd0, 1'b1, 1'b0, 16'h9999, 16'h0001,
                      BCD ? 16'h0000 : 16'h999A, BCD ? 4'b0110 : 4'b1000, BCD ? NIB : 1, "dec_add_wrap"});

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cmd = '0; dec = 1'b0; ci = 1'b0;
      data_a = '0; data_b = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_state", {out_valid, in_ready, result, no, zo, co, vo}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {out_valid, in_ready}, 32'b01);

      // Directed table
      foreach (tbl[i]) begin
         run_op(tbl[i].cmd, tbl[i].dec, tbl[i].ci, tbl[i].a, tbl[i].b, 0, r_got, f_got, lat_got);
         check($sformatf("%s result", tbl[i].name), 32'(r_got), 32'(tbl[i].r));
         check($sformatf("%s flags", tbl[i].name), 32'(f_got), 32'(tbl[i].f));
         check($sformatf("%s latency", tbl[i].name), 32'(lat_got), 32'(tbl[i].lat));
      end

      // Backpressure: result held, no new accept, then accept during drain.
      cmd = 4'd0; dec = 1'b0; ci = 1'b0; data_a = 16'h7FFF; data_b = 16'h0001; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_hold_%0d", i), {out_valid, in_ready, result, no, zo, co, vo},
               {11'd0, 1'b1, 1'b0, 16'h8000, 4'b1001});
         @(negedge clk);
      end
      out_ready = 1'b1; in_valid = 1'b1;
      cmd = 4'd1; data_a = 16'h0005; data_b = 16'h0005;
      #1;
      check("bp_ready_on_drain", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      check("bp_back_to_back", {out_valid, result, no, zo, co, vo},
            {11'd0, 1'b1, 16'h0000, 4'b0100});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_drained", {out_valid, in_ready}, 32'b01);

      // Reset while an op is in flight: nothing is emitted afterwards.
      cmd = 4'd0; dec = 1'b1; ci = 1'b1; data_a = 16'h1234; data_b = 16'h5678; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; dec = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_op", {out_valid, in_ready}, 32'b00);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_op_release", {out_valid, in_ready, result, no, zo, co, vo},
            {11'd0, 1'b0, 1'b1, 16'h0000, 4'b0000});
      lat_got = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) lat_got++;
      end
      check("rst_mid_op_no_output", 32'(lat_got), 32'd0);

      // Random ops against the model with random backpressure.
      for (int i = 0; i < 300; i++) begin
         rc  = 4'($urandom_range(0, 15));
         rd  = 1'($urandom_range(0, 1));
         rci = 1'($urandom_range(0, 1));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         model(rc, rd, rci, ra, rb, r_exp, f_exp, lat_exp);
         run_op(rc, rd, rci, ra, rb, int'($urandom_range(0, 3)), r_got, f_got, lat_got);
         check($sformatf("rnd%0d cmd%0d dec%0d a=%h b=%h result", i, rc, rd, ra, rb),
               32'(r_got), 32'(r_exp));
         check($sformatf("rnd%0d flags", i), 32'(f_got), 32'(f_exp));
         check($sformatf("rnd%0d latency", i), 32'(lat_got), 32'(lat_exp));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
